// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t     : controller states (IDLE, RUN, DONE), 2-bit encoding
//   count_width : width of the iteration counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int count_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sub_nbit.sv
// Combinational (WIDTH+1)-bit subtractor a - b, built as a ripple chain of
// full adders on ~b with carry-in 1 (same structure as the ripple adders).
// Ports:
//   a, b   : WIDTH+1-bit operands
//   diff   : low WIDTH bits of a - b
//   borrow : bit WIDTH of a - b. The divider only ever presents a < 2*b with
//            b < 2**WIDTH, so this sign bit is set exactly when a < b.
module sub_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] b_inv;
    logic [WIDTH:0] carry;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign diff[gi]    = a[gi] ^ b_inv[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b_inv[gi]) | (a[gi] & carry[gi]) |
                                 (b_inv[gi] & carry[gi]);
        end
    endgenerate

    // Top stage only needs its sum bit, which is the sign of the difference.
    assign borrow = a[WIDTH] ^ b_inv[WIDTH] ^ carry[WIDTH];

endmodule

// File: rtl/div_seq_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request a divide (honoured only in IDLE)
//   dividend, divisor   : operands, sampled with start
//   quotient, remainder : registered results, updated only on completion
//   busy                : high while iterating
//   done                : one-cycle completion pulse
//   div_by_zero         : set when the last completed operation had divisor 0
module div_seq_restoring
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = count_width(WIDTH);

    state_t          state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_work_reg;
    // The restored partial remainder is always < D, so WIDTH bits suffice;
    // the extra bit only exists in the shifted value fed to the subtractor.
    logic [WIDTH-1:0] r_work_reg;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    assign r_shift = {r_work_reg, q_work_reg[WIDTH-1]};

    sub_nbit #(.WIDTH(WIDTH)) u_sub (
        .a      (r_shift),
        .b      ({1'b0, d_reg}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    assign q_next = {q_work_reg[WIDTH-2:0], ~trial_borrow};
    assign r_next = trial_borrow ? r_shift[WIDTH-1:0] : trial_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            d_reg       <= '0;
            q_work_reg  <= '0;
            r_work_reg  <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done      <= 1'b0;
                    count_reg <= '0;
                    if (start) begin
                        if (divisor != '0) begin
                            d_reg       <= divisor;
                            q_work_reg  <= dividend;
                            r_work_reg  <= '0;
                            count_reg   <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state_reg   <= RUN;
                        end else begin
                            // Divide by zero completes immediately.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_work_reg <= q_next;
                    r_work_reg <= r_next;
                    if (count_reg == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    count_reg <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    count_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring (WIDTH=4): directed scenarios,
// an exhaustive sweep and random pairs against an arithmetic reference.
module tb_div_seq_restoring;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_seq_restoring #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic, divide-by-zero convention from the block's rules.
    task automatic ref_div(input int unsigned a, input int unsigned b,
                           output int unsigned q, output int unsigned r,
                           output int unsigned z, output int unsigned lat);
        if (b == 0) begin
            q = (1 << W) - 1; r = a; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = W + 1;
        end
    endtask

    // Issue one divide, wait for done (bounded), then check results,
    // latency, busy length and that done lasts exactly one cycle.
    task automatic run_div(input string tag, input int unsigned a, input int unsigned b,
                           input bit verbose);
        int unsigned q, r, z, lat;
        int n;
        int busy_cycles;
        ref_div(a, b, q, r, z, lat);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_len"}, busy_cycles, (b == 0) ? 0 : W);
        check({tag, "_quot"}, quotient, q);
        check({tag, "_rem"}, remainder, r);
        check({tag, "_dbz"}, div_by_zero, z);
        if (b != 0) begin
            check({tag, "_rem_lt_div"}, (remainder < divisor) ? 1 : 0, 1);
            check({tag, "_identity"}, quotient * b + remainder, a);
        end
        if (verbose)
            $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient,
                     remainder, div_by_zero, n);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int done_count;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("reset_quot", quotient, 0);
        check("reset_rem", remainder, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        // Basic cases, back-to-back
        run_div("t1_13_3", 13, 3, 1'b1);
        run_div("t2_15_1", 15, 1, 1'b1);
        run_div("t2_3_9", 3, 9, 1'b1);
        run_div("t3_7_0", 7, 0, 1'b1);
        run_div("t3_6_2", 6, 2, 1'b1);

        // Results hold through IDLE
        tick(); tick(); tick();
        check("hold_quot", quotient, 3);
        check("hold_rem", remainder, 0);

        // Start while running is dropped
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'd9; divisor = 4'd4; start = 1'b1;
        tick();
        start = 1'b0; dividend = 4'd1; divisor = 4'd1;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_count++;
            tick();
        end
        check("t4_done_count", done_count, 1);
        check("t4_quot", quotient, 2);
        check("t4_rem", remainder, 2);
        $display("drop-test 12/5 -> q=%0d r=%0d dones=%0d", quotient, remainder, done_count);

        // Reset during RUN aborts
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_quot", quotient, 0);
        check("t5_rst_rem", remainder, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) done_count++;
            tick();
        end
        check("t5_no_activity", done_count, 0);
        $display("reset-abort 14/3 -> outputs cleared, activity=%0d", done_count);
        run_div("t5_14_3", 14, 3, 1'b1);

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_div($sformatf("ex_%0d_%0d", a, b), a, b, 1'b0);
        $display("exhaustive sweep of 256 pairs complete, mismatches so far %0d", n_bad);

        // Random pairs
        for (int k = 0; k < 40; k++)
            run_div($sformatf("rnd%0d", k), $urandom_range(15), $urandom_range(15), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
